// File: rtl/rv32m_divider.sv
// rtl/rv32m_divider.sv - multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module rv32m_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             div_start,
  input  logic [1:0]       div_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             consume,
  input  logic             flush,
  output logic [WIDTH-1:0] div_result,
  output logic             div_ready,
  output logic             div_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_q, rem_q, dvs_q, result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sel_rem_q, quot_neg_q, rem_neg_q;

  // Operand conditioning at start; div_op[0]==0 selects the signed flavours.
  logic             signed_op, dividend_neg, divisor_neg;
  logic             div_by_zero, overflow, special;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, special_result;

  always_comb begin
    signed_op    = ~div_op[0];
    dividend_neg = signed_op & dividend[WIDTH-1];
    divisor_neg  = signed_op & divisor[WIDTH-1];
    dvd_mag      = dividend_neg ? -dividend : dividend;
    dvs_mag      = divisor_neg ? -divisor : divisor;
    div_by_zero  = (divisor == '0);
    overflow     = signed_op && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    special      = div_by_zero | overflow;
    if (div_by_zero)
      special_result = div_op[1] ? dividend : '1;
    else
      special_result = div_op[1] ? '0 : dividend;
  end

  // One restoring step; the shifted remainder needs WIDTH+1 bits before the compare.
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nxt, q_nxt, q_fix, rem_fix, final_result;

  always_comb begin
    rem_sh       = {rem_q, q_q[WIDTH-1]};
    rem_ge       = (rem_sh >= {1'b0, dvs_q});
    rem_nxt      = rem_ge ? (rem_sh[WIDTH-1:0] - dvs_q) : rem_sh[WIDTH-1:0];
    q_nxt        = {q_q[WIDTH-2:0], rem_ge};
    q_fix        = quot_neg_q ? -q_nxt : q_nxt;
    rem_fix      = rem_neg_q ? -rem_nxt : rem_nxt;
    final_result = sel_rem_q ? rem_fix : q_fix;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (div_start) state_nxt = special ? DONE : BUSY;
        BUSY:    if (cnt_q == CNT_W'(1)) state_nxt = DONE;
        DONE:    if (consume) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    div_ready  = (state == DONE);
    div_busy   = (state == BUSY);
    div_result = result_q;
  end

  // A flush freezes the datapath; result_q keeps whatever last completed.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      q_q        <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      sel_rem_q  <= 1'b0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (div_start) begin
            sel_rem_q  <= div_op[1];
            quot_neg_q <= dividend_neg ^ divisor_neg;
            rem_neg_q  <= dividend_neg;
            q_q        <= dvd_mag;
            dvs_q      <= dvs_mag;
            rem_q      <= '0;
            cnt_q      <= CNT_W'(WIDTH);
            if (special) result_q <= special_result;
          end
        end
        BUSY: begin
          q_q   <= q_nxt;
          rem_q <= rem_nxt;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) result_q <= final_result;
        end
        default: ;
      endcase
    end
  end

endmodule
